// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Header bit positions follow the standard 3-byte PS/2 mouse packet layout.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } mouse_state_e;

    localparam int BTN_LSB  = 0;
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;

    localparam int DELTA_W  = 9;
    localparam int ACC_W    = 12;
    localparam int POS_W    = 10;

endpackage

// File: rtl/mouse_axis_accum.sv
// Combinational per-axis cursor update: applies a signed delta and clamps to 0..LIMIT-1.
// SUBTRACT selects pos - delta, used for Y where PS/2 reports up-positive.
module mouse_axis_accum
    import ps2_mouse_pkg::*;
#(
    parameter int LIMIT    = 640,
    parameter bit SUBTRACT = 1'b0
) (
    input  logic [POS_W-1:0]          pos,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      ovf,
    output logic [POS_W-1:0]          pos_next
);

    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(LIMIT - 1);

    logic signed [ACC_W-1:0] pos_s;
    logic signed [ACC_W-1:0] delta_s;
    logic signed [ACC_W-1:0] sum;

    always_comb begin
        pos_s   = signed'({{(ACC_W-POS_W){1'b0}}, pos});
        delta_s = ovf ? '0 : {{(ACC_W-DELTA_W){delta[DELTA_W-1]}}, delta};
        sum     = SUBTRACT ? (pos_s - delta_s) : (pos_s + delta_s);
        if (sum < 0)
            pos_next = '0;
        else if (sum > MAX_S)
            pos_next = POS_W'(LIMIT - 1);
        else
            pos_next = sum[POS_W-1:0];
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet decoder: assembles 3-byte packets into a clamped cursor position.
// Define PS2_MOUSE_TIMEOUT_EN to abort partial packets after TIMEOUT_CYC idle cycles.
//
// state   | meaning
// WAIT_B0 | hunting for a header byte (bit3 set)
// WAIT_B1 | header latched, waiting for the X delta byte
// WAIT_B2 | X delta latched, waiting for the Y delta byte
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int INIT_X      = 6,
    parameter int INIT_Y      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done_tick,
    output logic [POS_W-1:0] mouse_x,
    output logic [POS_W-1:0] mouse_y,
    output logic [2:0]       buttons,
    output logic             pkt_valid,
    output logic             sync_err
);

    mouse_state_e      state;
    logic [7:0]        header;
    logic [7:0]        byte1;
    logic [POS_W-1:0]  x_next;
    logic [POS_W-1:0]  y_next;

    mouse_axis_accum #(.LIMIT(SCREEN_W), .SUBTRACT(1'b0)) u_axis_x (
        .pos      (mouse_x),
        .delta    ({header[XSIGN], byte1}),
        .ovf      (header[XOVF]),
        .pos_next (x_next)
    );

    // Y delta comes straight from the incoming byte so the update lands one cycle after byte2.
    mouse_axis_accum #(.LIMIT(SCREEN_H), .SUBTRACT(1'b1)) u_axis_y (
        .pos      (mouse_y),
        .delta    ({header[YSIGN], rx_data}),
        .ovf      (header[YOVF]),
        .pos_next (y_next)
    );

`ifdef PS2_MOUSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (rx_done_tick || state == WAIT_B0)
            tmo_cnt <= '0;
        else if (!tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_B0;
            header    <= '0;
            byte1     <= '0;
            mouse_x   <= POS_W'(INIT_X);
            mouse_y   <= POS_W'(INIT_Y);
            buttons   <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (rx_done_tick) begin
                case (state)
                    WAIT_B0: begin
                        if (rx_data[SYNC_BIT]) begin
                            header <= rx_data;
                            state  <= WAIT_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    WAIT_B1: begin
                        byte1 <= rx_data;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        mouse_x   <= x_next;
                        mouse_y   <= y_next;
                        buttons   <= header[BTN_LSB +: 3];
                        pkt_valid <= 1'b1;
                        state     <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end
`ifdef PS2_MOUSE_TIMEOUT_EN
            // A byte arriving on the expiry cycle takes priority over the abort.
            else if (state != WAIT_B0 && tmo_hit) begin
                state    <= WAIT_B0;
                sync_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Randomized bench for ps2_mouse_packet against a byte-level packet model.
// Timeout behaviour is checked when PS2_MOUSE_TIMEOUT_EN is defined.
module tb_ps2_mouse_packet;

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int TMO = 100;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] buttons;
    logic       pkt_valid;
    logic       sync_err;

    int n_tests;
    int n_fail;

    // model state: byte index within packet, header, first delta, position, buttons
    int m_idx, m_hdr, m_b1, m_x, m_y, m_btn;

    ps2_mouse_packet #(
        .SCREEN_W(W), .SCREEN_H(H), .TIMEOUT_CYC(TMO), .INIT_X(6), .INIT_Y(6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .buttons      (buttons),
        .pkt_valid    (pkt_valid),
        .sync_err     (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        rx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_idx = 0; m_hdr = 0; m_b1 = 0; m_x = 6; m_y = 6; m_btn = 0;
        check("rst_x", int'(mouse_x), 6);
        check("rst_y", int'(mouse_y), 6);
        check("rst_btn", int'(buttons), 0);
        check("rst_pkt", int'(pkt_valid), 0);
        check("rst_sync", int'(sync_err), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // gap = number of clock edges with no strobe before this byte's strobe edge
    task automatic send(input logic [7:0] b, input int gap);
        int exp_abort, idle_sync, idle_pkt, exp_pkt, exp_sync, dx, dy;
        exp_abort = 0; idle_sync = 0; idle_pkt = 0; exp_pkt = 0; exp_sync = 0;
`ifdef PS2_MOUSE_TIMEOUT_EN
        if (m_idx != 0 && gap > TMO) begin
            exp_abort = 1;
            m_idx = 0;
        end
`endif
        repeat (gap) begin
            @(posedge clk);
            #1;
            idle_sync += int'(sync_err);
            idle_pkt  += int'(pkt_valid);
        end
        if (gap > 0) begin
            check("idle_sync", idle_sync, exp_abort);
            check("idle_pkt", idle_pkt, 0);
        end
        case (m_idx)
            0: begin
                if (b[3]) begin m_hdr = int'(b); m_idx = 1; end
                else exp_sync = 1;
            end
            1: begin m_b1 = int'(b); m_idx = 2; end
            default: begin
                dx = m_b1 - (((m_hdr >> 4) & 1) != 0 ? 256 : 0);
                dy = int'(b) - (((m_hdr >> 5) & 1) != 0 ? 256 : 0);
                if (((m_hdr >> 6) & 1) != 0) dx = 0;
                if (((m_hdr >> 7) & 1) != 0) dy = 0;
                m_x = clamp(m_x + dx, W - 1);
                m_y = clamp(m_y - dy, H - 1);
                m_btn = m_hdr & 7;
                exp_pkt = 1;
                m_idx = 0;
            end
        endcase
        rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        check("pkt_valid", int'(pkt_valid), exp_pkt);
        check("sync_err", int'(sync_err), exp_sync);
        check("mouse_x", int'(mouse_x), m_x);
        check("mouse_y", int'(mouse_y), m_y);
        check("buttons", int'(buttons), m_btn);
    endtask

    initial begin
        logic [7:0] b;
        int gap;
        n_tests = 0;
        n_fail = 0;
        rx_data = 8'h00;
        rx_done_tick = 1'b0;
        rst = 1'b1;
        #2;
        do_reset();

        send(8'h09, 0); send(8'h05, 2); send(8'h03, 1);
        check("basic_x", int'(mouse_x), 11);
        check("basic_y", int'(mouse_y), 3);
        check("basic_btn", int'(buttons), 1);

        do_reset();
        send(8'h18, 0); send(8'hF0, 0); send(8'h00, 0);
        check("clamp_lo_x", int'(mouse_x), 0);
        check("clamp_lo_y", int'(mouse_y), 6);

        do_reset();
        send(8'h08, 0); send(8'hFF, 0); send(8'h00, 0);
        send(8'h08, 0); send(8'hFF, 0); send(8'h00, 0);
        send(8'h08, 0); send(8'h72, 0); send(8'h00, 0);
        check("pre_ovf_x", int'(mouse_x), 630);
        send(8'h48, 0); send(8'h7F, 0); send(8'h00, 0);
        check("ovf_x", int'(mouse_x), 630);

        do_reset();
        send(8'h00, 0); send(8'h01, 0);
        send(8'h08, 0); send(8'h02, 0); send(8'h02, 0);
        check("resync_x", int'(mouse_x), 8);
        check("resync_y", int'(mouse_y), 4);

        do_reset();
`ifdef PS2_MOUSE_TIMEOUT_EN
        send(8'h08, 0); send(8'h08, TMO + 1); send(8'h01, 0); send(8'h01, 0);
        check("tmo_x", int'(mouse_x), 7);
        check("tmo_y", int'(mouse_y), 5);
        send(8'h08, 0); send(8'h01, TMO); send(8'h01, TMO);
        check("tmo_edge_x", int'(mouse_x), 8);
        check("tmo_edge_y", int'(mouse_y), 4);
`else
        send(8'h08, 0); send(8'h01, TMO + 50); send(8'h01, 0);
        check("notmo_x", int'(mouse_x), 7);
        check("notmo_y", int'(mouse_y), 5);
`endif

        do_reset();
        send(8'h08, 0); send(8'h05, 0);
        do_reset();
        send(8'h08, 0); send(8'h00, 0); send(8'h00, 0);
        check("midrst_x", int'(mouse_x), 6);
        check("midrst_y", int'(mouse_y), 6);

        for (int i = 0; i < 600; i++) begin
            b = 8'($urandom_range(0, 255));
            if (m_idx == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
            if ($urandom_range(0, 24) == 0) gap = TMO + $urandom_range(0, 2);
            else gap = $urandom_range(0, 3);
            if ($urandom_range(0, 79) == 0) do_reset();
            send(b, gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet.md
PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640: horizontal cursor range, 0..SCREEN_W-1.
REQ-002 SHALL have parameter SCREEN_H, default 480: vertical cursor range, 0..SCREEN_H-1.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_500_000: maximum idle clk cycles allowed between bytes of one packet.
REQ-004 SHALL have parameter INIT_X, default 6, and INIT_Y, default 6: the cursor position after reset.
REQ-005 clk  input  1  system clock; one clock domain, all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rx_data  input  8  byte from the upstream PS/2 receiver.
REQ-008 rx_done_tick  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 mouse_x  output  10  cursor X, screen pixels.
REQ-010 mouse_y  output  10  cursor Y, screen pixels, down positive.
REQ-011 buttons  output  3  {middle, right, left} from the last accepted packet.
REQ-012 pkt_valid  output  1  one-cycle strobe on each position/buttons update.
REQ-013 sync_err  output  1  one-cycle strobe on each discarded byte or aborted packet.

Function
REQ-014 SHALL use a 3-state FSM: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0; each transition occurs only on rx_done_tick.
REQ-015 In WAIT_B0, a byte with bit3=0 SHALL be dropped, the FSM SHALL stay in WAIT_B0, and sync_err SHALL pulse in the next cycle.
REQ-016 In WAIT_B0, a byte with bit3=1 SHALL be latched as the header.
REQ-017 Header fields: bits[2:0] are the buttons; bit4 is the X sign; bit5 is the Y sign; bit6 is X overflow; bit7 is Y overflow.
REQ-018 Byte1 SHALL form dx = {X sign, byte1}, 9-bit two's complement, range -256..+255.
REQ-019 Byte2 SHALL form dy = {Y sign, byte2}, 9-bit two's complement, range -256..+255.
REQ-020 On byte2, the next cycle SHALL perform: mouse_x <= clamp(mouse_x + dx); mouse_y <= clamp(mouse_y - dy); buttons <= header[2:0]; pkt_valid=1.
REQ-021 Latency: exactly one cycle from byte2's rx_done_tick to pkt_valid.
REQ-022 Arithmetic SHALL be computed at 12-bit signed width.
REQ-023 Clamping: results below 0 become 0; results above SCREEN_W-1 become SCREEN_W-1 (X); results above SCREEN_H-1 become SCREEN_H-1 (Y).
REQ-024 If the X overflow bit is set, dx SHALL be treated as 0; if the Y overflow bit is set, dy SHALL be treated as 0; buttons SHALL still update.
REQ-025 In WAIT_B1 or WAIT_B2, if more than TIMEOUT_CYC cycles pass with no rx_done_tick, the packet SHALL be aborted, the FSM SHALL return to WAIT_B0, and sync_err SHALL pulse once.
REQ-026 The timeout counter SHALL clear on every rx_done_tick and SHALL hold at 0 while in WAIT_B0.
REQ-027 If rx_done_tick arrives in the same cycle the timeout expires, the byte SHALL win: it is accepted and no abort occurs.
REQ-028 pkt_valid and sync_err SHALL never be asserted in the same cycle.

Reset
REQ-029 While rst=0, the FSM SHALL be in WAIT_B0 with mouse_x=INIT_X, mouse_y=INIT_Y, buttons=0, pkt_valid=0, sync_err=0, timeout counter=0, header=0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet; the first byte after release SHALL be treated as a header candidate.

Configuration
REQ-031 With macro PS2_MOUSE_TIMEOUT_EN defined, the timeout counter and abort path (REQ-025..027) SHALL be present.
REQ-032 Without PS2_MOUSE_TIMEOUT_EN, no timeout counter SHALL exist, partial packets SHALL wait indefinitely, and sync_err SHALL arise only from REQ-015.

Structure
REQ-033 Package ps2_mouse_pkg SHALL hold: the FSM state enum typedef; header bit-index constants (BTN_LSB, XSIGN, YSIGN, XOVF, YOVF, SYNC_BIT); and the delta width constant (9).
REQ-034 Sub-module mouse_axis_accum SHALL take a 10-bit position, a 9-bit signed delta, an overflow flag and a limit parameter, and SHALL return the clamped position.
REQ-035 mouse_axis_accum SHALL be combinational and instantiated twice (X, Y); all registers SHALL remain in the parent.

Verification
REQ-036 After reset, send bytes 0x09, 0x05, 0x03 -> pkt_valid pulse; mouse_x=11; mouse_y=3; buttons=3'b001.
REQ-037 From (6,6), send 0x18, 0xF0 (dx=-16), 0x00 -> mouse_x=0 (clamped), mouse_y=6; no sync_err.
REQ-038 From (630,6), send 0x48, 0x7F, 0x00 (X overflow) -> mouse_x=630 unchanged; pkt_valid still pulses.
REQ-039 Send 0x00, 0x01, then 0x08, 0x02, 0x02 -> two sync_err pulses, then one packet with mouse_x=8, mouse_y=4.
REQ-040 With PS2_MOUSE_TIMEOUT_EN and TIMEOUT_CYC=100: send 0x08, idle 101 cycles, then 0x08, 0x01, 0x01 -> one sync_err, then one pkt_valid; mouse_x=7, mouse_y=5.
REQ-041 Assert rst after byte1 of a packet, release, then send 0x08, 0x00, 0x00 -> position reads (6,6) with exactly one pkt_valid.
